// File: rtl/trng_pkg.sv
// Shared types and constants for the TRNG entropy buffer.
package trng_pkg;

  // Width of the saturating lost-word counter.
  localparam int unsigned DROP_CNT_W = 8;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StFault
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with a separate up/down level counter and a flush input.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] level,
  output logic                   empty,
  output logic                   full
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [LvlW-1:0]  level_q;

  // Storage write; no reset needed since reads are masked while empty.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); flush overrides push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop) begin
        level_q <= level_q + LvlW'(1);
      end else if (pop && !push) begin
        level_q <= level_q - LvlW'(1);
      end
    end
  end

  // Status and head word; head reads as zero while empty so reset leaves it at 0.
  always_comb begin
    empty = (level_q == '0);
    full  = (level_q == LvlW'(DEPTH));
    level = level_q;
    rdata = empty ? '0 : mem_q[rd_ptr_q];
  end

endmodule

// File: rtl/trng_entropy_buffer.sv
// Entropy prefetch buffer: refill FSM, repetition-count health test and drop counter
// in front of a show-ahead FIFO.
module trng_entropy_buffer
  import trng_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned REP_LIMIT = 4,
  parameter int unsigned LOW_WATER = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   trng_request,
  input  logic [WIDTH-1:0]       trng_data,
  input  logic                   trng_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   health_fail,
  input  logic                   clear_fail,
  output logic [DROP_CNT_W-1:0]  drop_count
);

  localparam int unsigned LvlW = $clog2(DEPTH) + 1;
  localparam int unsigned RepW = $clog2(REP_LIMIT) + 1;

  state_e                state_q;
  logic                  trng_request_q;
  logic                  health_fail_q;
  logic [WIDTH-1:0]      prev_q, prev_d;
  logic [RepW-1:0]       rep_cnt_q, rep_cnt_d;
  logic [DROP_CNT_W-1:0] drop_count_q, drop_count_d;

  logic fault, accept, repeat_word, trip, push, pop, drop, empty, full;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (trng_data),
    .pop   (pop),
    .flush (trip),
    .rdata (out_data),
    .level (level),
    .empty (empty),
    .full  (full)
  );

  // Decode source/consumer handshakes into push, pop, drop and health-trip events.
  always_comb begin
    fault       = (state_q == StFault);
    accept      = trng_ready && !fault;
    repeat_word = (trng_data == prev_q);
    trip        = accept && repeat_word && ((rep_cnt_q + RepW'(1)) == RepW'(REP_LIMIT - 1));
    out_valid   = !empty && !fault;
    // A trip flushes the FIFO, so a coincident pop must not also move the read pointer.
    pop         = out_valid && out_ready && !trip;
    push        = accept && !repeat_word && (!full || pop);
    // Words lost to a full FIFO, or anything arriving while faulted (clear wins the tie).
    drop        = (accept && !repeat_word && full && !pop) ||
                  (fault && trng_ready && !clear_fail);
  end

  // Next-state for the health-test history and the saturating drop counter.
  always_comb begin
    prev_d       = prev_q;
    rep_cnt_d    = rep_cnt_q;
    drop_count_d = drop_count_q;
    if (fault && clear_fail) begin
      rep_cnt_d    = '0;
      drop_count_d = '0;
    end else begin
      if (accept) begin
        prev_d    = trng_data;
        rep_cnt_d = repeat_word ? rep_cnt_q + RepW'(1) : '0;
      end
      if (drop && (drop_count_q != '1)) begin
        drop_count_d = drop_count_q + DROP_CNT_W'(1);
      end
    end
  end

  // Health-test history and drop counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q       <= '0;
      rep_cnt_q    <= '0;
      drop_count_q <= '0;
    end else begin
      prev_q       <= prev_d;
      rep_cnt_q    <= rep_cnt_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Refill/fault FSM with registered request and fault flag; a trip overrides any state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      trng_request_q <= 1'b0;
      health_fail_q  <= 1'b0;
    end else if (trip) begin
      state_q        <= StFault;
      trng_request_q <= 1'b0;
      health_fail_q  <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (level <= LvlW'(LOW_WATER)) begin
            state_q        <= StFill;
            trng_request_q <= 1'b1;
          end
        end
        StFill: begin
          if (level == LvlW'(DEPTH)) begin
            state_q        <= StIdle;
            trng_request_q <= 1'b0;
          end
        end
        StFault: begin
          if (clear_fail) begin
            state_q       <= StIdle;
            health_fail_q <= 1'b0;
          end
        end
        default: begin
          state_q        <= StIdle;
          trng_request_q <= 1'b0;
        end
      endcase
    end
  end

  assign trng_request = trng_request_q;
  assign health_fail  = health_fail_q;
  assign drop_count   = drop_count_q;

endmodule

// File: tb/tb_trng_entropy_buffer.sv
// Scoreboard bench for trng_entropy_buffer: stimulus pushes expected words, a negedge
// monitor pops and compares on every consumer handshake.
module tb_trng_entropy_buffer;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             trng_request;
  logic [WIDTH-1:0] trng_data = '0;
  logic             trng_ready = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [3:0]       level;
  logic             health_fail;
  logic             clear_fail = 1'b0;
  logic [7:0]       drop_count;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  logic [WIDTH-1:0] exp_q[$];

  trng_entropy_buffer #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .REP_LIMIT (4),
    .LOW_WATER (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .trng_request (trng_request),
    .trng_data    (trng_data),
    .trng_ready   (trng_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .level        (level),
    .health_fail  (health_fail),
    .clear_fail   (clear_fail),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every handshake must present the oldest outstanding expected word.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL pop_unexpected: got 0x%0h expected no word", out_data);
      end else begin
        check("pop_data", 64'(out_data), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One source pulse followed by an idle cycle; optionally record it as expected output.
  task automatic send_gap(input logic [WIDTH-1:0] w, input bit expect_out);
    trng_data  = w;
    trng_ready = 1'b1;
    if (expect_out) exp_q.push_back(w);
    cycles(1);
    trng_ready = 1'b0;
    cycles(1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"},   64'(trng_request), 64'd0);
    check({tag, "_valid"}, 64'(out_valid),    64'd0);
    check({tag, "_data"},  64'(out_data),     64'd0);
    check({tag, "_level"}, 64'(level),        64'd0);
    check({tag, "_fail"},  64'(health_fail),  64'd0);
    check({tag, "_drop"},  64'(drop_count),   64'd0);
  endtask

  initial begin
    // Reset state
    cycles(2);
    check_all_zero("reset");
    rst = 1'b0;
    cycles(1);
    check("req_after_reset", 64'(trng_request), 64'd1);

    // 1 Fill with 1..8, consumer stalled
    for (int i = 1; i <= 8; i++) begin
      send_gap(WIDTH'(i), 1'b1);
      if (i == 1) begin
        check("fill_first_valid", 64'(out_valid), 64'd1);
        check("fill_first_data",  64'(out_data),  64'd1);
      end
      if (i == 4) check("fill_req_held", 64'(trng_request), 64'd1);
    end
    check("fill_level", 64'(level),        64'd8);
    check("fill_req",   64'(trng_request), 64'd0);
    check("fill_head",  64'(out_data),     64'd1);

    // 2 Drain seven words
    out_ready = 1'b1;
    cycles(7);
    out_ready = 1'b0;
    check("drain_level", 64'(level),        64'd1);
    check("drain_req",   64'(trng_request), 64'd1);
    check("drain_head",  64'(out_data),     64'd8);

    // 3 Health trip on four identical words
    send_gap(32'hA5A5_A5A5, 1'b1);
    send_gap(32'hA5A5_A5A5, 1'b0);
    send_gap(32'hA5A5_A5A5, 1'b0);
    check("rep_discard_level", 64'(level), 64'd2);
    send_gap(32'hA5A5_A5A5, 1'b0);
    exp_q.delete();
    check("trip_fail",  64'(health_fail),  64'd1);
    check("trip_level", 64'(level),        64'd0);
    check("trip_valid", 64'(out_valid),    64'd0);
    check("trip_req",   64'(trng_request), 64'd0);
    send_gap(32'h0000_0011, 1'b0);
    check("fault_drop", 64'(drop_count), 64'd1);
    check("fault_level", 64'(level),     64'd0);

    // 4 Recovery: clear together with a pulse that must be dropped
    trng_data  = 32'h0000_0022;
    trng_ready = 1'b1;
    clear_fail = 1'b1;
    cycles(1);
    trng_ready = 1'b0;
    clear_fail = 1'b0;
    check("clear_fail_flag", 64'(health_fail), 64'd0);
    check("clear_drop",      64'(drop_count),  64'd0);
    check("clear_level",     64'(level),       64'd0);
    cycles(1);
    check("clear_req", 64'(trng_request), 64'd1);
    for (int i = 0; i < 8; i++) send_gap(WIDTH'(32'h100 + i), 1'b1);
    check("refill_level", 64'(level),      64'd8);
    check("refill_head",  64'(out_data),   64'h100);
    check("refill_drop",  64'(drop_count), 64'd0);

    // 5 Overflow without and with a coincident pop
    for (int i = 0; i < 3; i++) send_gap(WIDTH'(32'h200 + i), 1'b0);
    check("ovf_drop",  64'(drop_count), 64'd3);
    check("ovf_level", 64'(level),      64'd8);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      trng_data  = WIDTH'(32'h300 + i);
      trng_ready = 1'b1;
      exp_q.push_back(WIDTH'(32'h300 + i));
      cycles(1);
    end
    trng_ready = 1'b0;
    out_ready  = 1'b0;
    check("ovf_pop_level", 64'(level),      64'd8);
    check("ovf_pop_drop",  64'(drop_count), 64'd3);

    // 6 Reset mid-fill at level 5 with request high
    out_ready = 1'b1;
    cycles(6);
    out_ready = 1'b0;
    check("pre6_level", 64'(level), 64'd2);
    cycles(1);
    for (int i = 0; i < 3; i++) send_gap(WIDTH'(32'h400 + i), 1'b1);
    check("pre6_level5", 64'(level),        64'd5);
    check("pre6_req",    64'(trng_request), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("midreset");
    exp_q.delete();
    cycles(1);
    rst = 1'b0;
    cycles(1);
    check("post_reset_req", 64'(trng_request), 64'd1);
    send_gap(32'h0000_0500, 1'b1);
    out_ready = 1'b1;
    cycles(1);
    out_ready = 1'b0;
    check("final_level", 64'(level), 64'd0);
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
